// File: rtl/mem_stage.sv
// mem_stage
// Memory-access pipeline stage, placed between execute and write-back.
// It registers the execute-to-memory bus under a valid/allowin handshake.
// It aligns and extends load data returned by the synchronous data SRAM.
// It keeps that read data alive while write-back stalls.
//
// Ports:
//   clk             sole clock, rising edge
//   reset           asynchronous, active-high
//   ex_mem_valid    execute stage presents a completed instruction
//   ex_mem_bus      108-bit execute-to-memory bus
//                   {gr_we, res_from_mem, mem_type[2:0], addr_low2[1:0],
//                    dest[4:0], pc, inst, ex_result}
//   mem_allowin     this stage can accept from execute this cycle
//   data_sram_rdata SRAM read data, valid in the first resident cycle only
//   mem_wb_valid    finished instruction offered to write-back
//   wb_allowin      write-back accepts this cycle
//   mem_wb_bus      {gr_we, dest, pc, inst, final_result}
//   mem_id_bus      {mem_bypass, dest, final_result} for decode forwarding
module mem_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ex_mem_valid,
  input  logic [107:0] ex_mem_bus,
  output logic         mem_allowin,
  input  logic [31:0]  data_sram_rdata,
  output logic         mem_wb_valid,
  input  logic         wb_allowin,
  output logic [101:0] mem_wb_bus,
  output logic [37:0]  mem_id_bus
);

  // Load-type encodings carried in mem_type.
  // Any encoding not listed here falls back to a whole-word load.
  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b101,
    LD_HU = 3'b110
  } memType_e;

  logic         memValid_q, memValid_d;
  logic [107:0] bus_q, bus_d;
  logic         rdataHeld_q, rdataHeld_d;
  logic [31:0]  rdataHold_q, rdataHold_d;

  logic         memReadyGo;
  logic         acceptNew;

  logic         grWe;
  logic         resFromMem;
  logic [2:0]   memType;
  logic [1:0]   addrLow2;
  logic [4:0]   dest;
  logic [31:0]  pc;
  logic [31:0]  inst;
  logic [31:0]  exResult;

  logic [31:0]  loadWord;
  logic [31:0]  shiftedWord;
  logic [7:0]   loadByte;
  logic [15:0]  loadHalf;
  logic [31:0]  loadResult;
  logic [31:0]  finalResult;

  // Field unpacking of the registered execute bus.
  assign grWe       = bus_q[107];
  assign resFromMem = bus_q[106];
  assign memType    = bus_q[105:103];
  assign addrLow2   = bus_q[102:101];
  assign dest       = bus_q[100:96];
  assign pc         = bus_q[95:64];
  assign inst       = bus_q[63:32];
  assign exResult   = bus_q[31:0];

  // The stage always finishes in one cycle.
  // Only a downstream stall can keep an instruction resident.
  assign memReadyGo   = 1'b1;
  assign mem_allowin  = ~memValid_q | (memReadyGo & wb_allowin);
  assign mem_wb_valid = memValid_q & memReadyGo;
  assign acceptNew    = ex_mem_valid & mem_allowin;

  // Next-state logic for the valid bit, the bus register and the rdata hold.
  // A newly accepted instruction always clears the hold flag,
  // so that it reads live SRAM data in its first cycle.
  // The hold only captures on the first stalled edge.
  // That edge is the last one at which the SRAM output is still valid.
  always_comb begin
    memValid_d  = memValid_q;
    bus_d       = bus_q;
    rdataHeld_d = rdataHeld_q;
    rdataHold_d = rdataHold_q;
    if (mem_allowin) begin
      memValid_d = ex_mem_valid;
    end
    if (acceptNew) begin
      bus_d       = ex_mem_bus;
      rdataHeld_d = 1'b0;
    end else if (memValid_q & ~wb_allowin & ~rdataHeld_q) begin
      rdataHeld_d = 1'b1;
      rdataHold_d = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memValid_q  <= 1'b0;
      bus_q       <= '0;
      rdataHeld_q <= 1'b0;
      rdataHold_q <= '0;
    end else begin
      memValid_q  <= memValid_d;
      bus_q       <= bus_d;
      rdataHeld_q <= rdataHeld_d;
      rdataHold_q <= rdataHold_d;
    end
  end

  // Pick live SRAM data in the first resident cycle.
  // Once a stall has captured it, use the held copy instead.
  assign loadWord = rdataHeld_q ? rdataHold_q : data_sram_rdata;

  // Shift the addressed byte down to bit 0.
  // Halfword selection uses only addr_low2[1], so the low address bit is ignored.
  assign shiftedWord = loadWord >> {addrLow2, 3'b000};
  assign loadByte    = shiftedWord[7:0];
  assign loadHalf    = addrLow2[1] ? loadWord[31:16] : loadWord[15:0];

  // Extend the selected byte or halfword according to the load type.
  always_comb begin
    loadResult = loadWord;
    case (memType)
      LD_B:    loadResult = {{24{loadByte[7]}}, loadByte};
      LD_BU:   loadResult = {24'h000000, loadByte};
      LD_H:    loadResult = {{16{loadHalf[15]}}, loadHalf};
      LD_HU:   loadResult = {16'h0000, loadHalf};
      default: loadResult = loadWord;
    endcase
  end

  assign finalResult = resFromMem ? loadResult : exResult;

  // gr_we goes to write-back unqualified, because write-back gates it with its own valid.
  // The forwarding bit, however, must be qualified by this stage's valid.
  assign mem_wb_bus = {grWe, dest, pc, inst, finalResult};
  assign mem_id_bus = {memValid_q & grWe, dest, finalResult};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Directed testbench for mem_stage.
// Every expected value is computed by hand from the load-alignment rules.
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         ex_mem_valid;
  logic [107:0] ex_mem_bus;
  logic         mem_allowin;
  logic [31:0]  data_sram_rdata;
  logic         mem_wb_valid;
  logic         wb_allowin;
  logic [101:0] mem_wb_bus;
  logic [37:0]  mem_id_bus;

  int compareCount  = 0;
  int mismatchCount = 0;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ex_mem_valid    (ex_mem_valid),
    .ex_mem_bus      (ex_mem_bus),
    .mem_allowin     (mem_allowin),
    .data_sram_rdata (data_sram_rdata),
    .mem_wb_valid    (mem_wb_valid),
    .wb_allowin      (wb_allowin),
    .mem_wb_bus      (mem_wb_bus),
    .mem_id_bus      (mem_id_bus)
  );

  // Free-running clock.
  // Rising edges fall at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  // The comparison is counted, and a FAIL line is printed on mismatch.
  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compareCount++;
    if (obs !== exp) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive every stage input in one step.
  task automatic applyStimulus(input logic v, input logic [107:0] b, input logic wa, input logic [31:0] rd);
    ex_mem_valid    = v;
    ex_mem_bus      = b;
    wb_allowin      = wa;
    data_sram_rdata = rd;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [107:0] mkBus(input logic grWe, input logic resMem, input logic [2:0] mt,
                                         input logic [1:0] low2, input logic [4:0] dst,
                                         input logic [31:0] exRes);
    return {grWe, resMem, mt, low2, dst, 32'h1C000100, 32'h28800000, exRes};
  endfunction

  // Load alignment table: {mem_type, addr_low2, rdata, expected}.
  typedef struct {
    logic [2:0]  mt;
    logic [1:0]  low2;
    logic [31:0] rdata;
    logic [31:0] exp;
  } loadVec_t;

  loadVec_t loads[8];

  initial begin
    loads[0] = '{3'b001, 2'd3, 32'h80123456, 32'hFFFFFF80};
    loads[1] = '{3'b110, 2'd2, 32'h8001ABCD, 32'h00008001};
    loads[2] = '{3'b010, 2'd2, 32'h8001ABCD, 32'hFFFF8001};
    loads[3] = '{3'b000, 2'd2, 32'h8001ABCD, 32'h8001ABCD};
    loads[4] = '{3'b101, 2'd1, 32'h0000FF00, 32'h000000FF};
    loads[5] = '{3'b010, 2'd3, 32'h8001ABCD, 32'hFFFF8001};
    loads[6] = '{3'b111, 2'd1, 32'hCAFEF00D, 32'hCAFEF00D};
    loads[7] = '{3'b001, 2'd0, 32'h0000007F, 32'h0000007F};

    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 32'h0);
    #3;
    checkOutput("reset_valid",   mem_wb_valid, 1'b1 ^ 1'b1);
    checkOutput("reset_allowin", mem_allowin, 1'b1);
    checkOutput("reset_wbbus",   mem_wb_bus, 102'h0);
    checkOutput("reset_idbus",   mem_id_bus, 38'h0);
    #10;
    reset = 1'b0;
    tick();

    // Each load is accepted, shown for one cycle with its rdata, and then released.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, mkBus(1'b1, 1'b1, loads[i].mt, loads[i].low2, 5'd7, 32'h0), 1'b1, 32'h0);
      tick();
      applyStimulus(1'b0, '0, 1'b1, loads[i].rdata);
      #1;
      checkOutput($sformatf("load%0d_valid", i), mem_wb_valid, 1'b1);
      checkOutput($sformatf("load%0d_result", i), mem_wb_bus[31:0], loads[i].exp);
      checkOutput($sformatf("load%0d_idbus", i), mem_id_bus, {1'b1, 5'd7, loads[i].exp});
      tick();
      checkOutput($sformatf("load%0d_gone", i), mem_wb_valid, 1'b0);
    end

    // A stalled ld.w must keep its first-cycle data while the SRAM output changes underneath it.
    applyStimulus(1'b1, mkBus(1'b1, 1'b1, 3'b000, 2'd0, 5'd9, 32'h0), 1'b1, 32'h0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 32'h11223344);
    #1;
    checkOutput("stall0_result",  mem_wb_bus[31:0], 32'h11223344);
    checkOutput("stall0_allowin", mem_allowin, 1'b0);
    for (int c = 1; c < 3; c++) begin
      tick();
      data_sram_rdata = 32'hDEADBEEF;
      #1;
      checkOutput($sformatf("stall%0d_result", c),  mem_wb_bus[31:0], 32'h11223344);
      checkOutput($sformatf("stall%0d_allowin", c), mem_allowin, 1'b0);
      checkOutput($sformatf("stall%0d_valid", c),   mem_wb_valid, 1'b1);
    end
    tick();
    wb_allowin = 1'b1;
    #1;
    checkOutput("stall_release_result",  mem_wb_bus[31:0], 32'h11223344);
    checkOutput("stall_release_allowin", mem_allowin, 1'b1);
    tick();
    checkOutput("stall_left", mem_wb_valid, 1'b0);

    // An ALU op followed directly by ld.bu, with no bubble between them.
    applyStimulus(1'b1, mkBus(1'b1, 1'b0, 3'b000, 2'd0, 5'd4, 32'h5), 1'b1, 32'h0);
    tick();
    applyStimulus(1'b1, mkBus(1'b1, 1'b1, 3'b101, 2'd0, 5'd6, 32'h0), 1'b1, 32'h0);
    #1;
    checkOutput("b2b_alu_valid",  mem_wb_valid, 1'b1);
    checkOutput("b2b_alu_result", mem_wb_bus[31:0], 32'h5);
    checkOutput("b2b_alu_idbus",  mem_id_bus, {1'b1, 5'd4, 32'h5});
    tick();
    applyStimulus(1'b0, '0, 1'b1, 32'h123456FF);
    #1;
    checkOutput("b2b_ld_valid",  mem_wb_valid, 1'b1);
    checkOutput("b2b_ld_result", mem_wb_bus[31:0], 32'h000000FF);
    tick();
    checkOutput("b2b_empty_bypass", mem_id_bus[37], 1'b0);

    // A store passes ex_result through and never raises the bypass bit.
    applyStimulus(1'b1, mkBus(1'b0, 1'b0, 3'b000, 2'd0, 5'd3, 32'h00001234), 1'b1, 32'h0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 32'hFFFFFFFF);
    #1;
    checkOutput("store_bypass", mem_id_bus[37], 1'b0);
    checkOutput("store_result", mem_wb_bus[31:0], 32'h00001234);
    checkOutput("store_grwe",   mem_wb_bus[101], 1'b0);
    tick();

    // Reset asserted mid-stall and between edges drops the instruction immediately.
    applyStimulus(1'b1, mkBus(1'b1, 1'b1, 3'b000, 2'd0, 5'd2, 32'h0), 1'b1, 32'h0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 32'hAAAA5555);
    tick();
    data_sram_rdata = 32'h0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_valid",   mem_wb_valid, 1'b0);
    checkOutput("midreset_allowin", mem_allowin, 1'b1);
    checkOutput("midreset_wbbus",   mem_wb_bus, 102'h0);
    #2;
    reset = 1'b0;
    applyStimulus(1'b1, mkBus(1'b1, 1'b1, 3'b000, 2'd0, 5'd2, 32'h0), 1'b1, 32'h0);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 32'h13579BDF);
    #1;
    checkOutput("postreset_valid",  mem_wb_valid, 1'b1);
    checkOutput("postreset_result", mem_wb_bus[31:0], 32'h13579BDF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
